// File: rtl/alu_muldiv_seq.sv
// Unsigned MUL (low word), DIVU and REMU computed by iterating an external single-cycle ALU.
// Latency: MUL WIDTH+1, DIVU/REMU 2*WIDTH+1, divide-by-zero and reserved op 1 cycle from accept.
// Backpressure: req_ready only in IDLE; one-cycle resp_valid strobe, consumer must sample it.
module alu_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL     = 3'd1,
        DIV_CMP = 3'd2,
        DIV_SUB = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ge_q, ge_d;
    logic [WIDTH-1:0] rs;

    assign rs          = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    assign req_ready   = (state_q == IDLE) & ~rst;
    assign resp_valid  = (state_q == DONE) & ~rst;
    assign resp_result = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            ge_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            ge_q     <= ge_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        ge_d     = ge_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d = req_op;
                    case (req_op)
                        OP_MUL: begin
                            state_d  = MUL;
                            acc_d    = '0;
                            mcand_d  = req_a;
                            mplier_d = req_b;
                            cnt_d    = '0;
                        end
                        OP_DIVU, OP_REMU: begin
                            if (req_b == '0) begin
                                state_d  = DONE;
                                result_d = (req_op == OP_DIVU) ? '1 : req_a;
                            end else begin
                                state_d = DIV_CMP;
                                rem_d   = '0;
                                dvd_d   = req_a;
                                dvs_d   = req_b;
                                quo_d   = '0;
                                cnt_d   = '0;
                            end
                        end
                        default: begin
                            state_d  = DONE;
                            result_d = '0;
                        end
                    endcase
                end
            end
            MUL: begin
                alu_a    = acc_q;
                alu_b    = mplier_q[0] ? mcand_q : '0;
                acc_d    = alu_out;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    result_d = alu_out;
                end
            end
            DIV_CMP: begin
                alu_ctrl = ALU_SLTU;
                alu_a    = rs;
                alu_b    = dvs_q;
                rem_d    = rs;
                dvd_d    = dvd_q << 1;
                // The bit shifted out of rem means rs exceeds WIDTH bits, so it is >= dvs.
                ge_d     = rem_q[WIDTH-1] | ~alu_out[0];
                state_d  = DIV_SUB;
            end
            DIV_SUB: begin
                alu_ctrl = ALU_SUB;
                alu_a    = rem_q;
                alu_b    = dvs_q;
                if (ge_q) begin
                    rem_d = alu_out;
                end
                quo_d = {quo_q[WIDTH-2:0], ge_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    result_d = (op_q == OP_DIVU) ? {quo_q[WIDTH-2:0], ge_q}
                                                 : (ge_q ? alu_out : rem_q);
                end else begin
                    state_d = DIV_CMP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural model of the external ALU.
module tb_alu_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic [31:0] resp_result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_out;

    int n_chk  = 0;
    int n_fail = 0;

    alu_muldiv_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_out     (alu_out)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_out = '0;
        case (alu_ctrl)
            3'b000:  alu_out = alu_a + alu_b;
            3'b001:  alu_out = alu_a - alu_b;
            3'b111:  alu_out = {31'b0, (alu_a < alu_b)};
            default: alu_out = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for req_ready, presents the request and lets one edge accept it.
    task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold);
        int w = 0;
        while (req_ready !== 1'b1 && w < 100) begin
            @(posedge clk); #1; w++;
        end
        chk("accept_ready", {31'b0, req_ready}, 32'd1);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // Called in cycle 1 after the accept edge; counts cycles until resp_valid.
    task automatic wait_resp(input string tag, input logic [31:0] exp, input int exp_lat,
                             input bit scramble);
        int cyc = 1;
        bit rdy_bad = 1'b0;
        while (resp_valid !== 1'b1 && cyc < 200) begin
            if (req_ready !== 1'b0) rdy_bad = 1'b1;
            if (scramble) req_a = $urandom;
            @(posedge clk); #1; cyc++;
        end
        chk({tag, "_lat"}, cyc, exp_lat);
        chk({tag, "_res"}, resp_result, exp);
        chk({tag, "_busy_rdy"}, {31'b0, rdy_bad}, 32'd0);
        chk({tag, "_done_rdy"}, {31'b0, req_ready}, 32'd0);
        if (scramble) req_a = $urandom;
        @(posedge clk); #1;
        chk({tag, "_vld_drop"}, {31'b0, resp_valid}, 32'd0);
        chk({tag, "_idle_rdy"}, {31'b0, req_ready}, 32'd1);
        chk({tag, "_hold"}, resp_result, exp);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_a     = '0;
        req_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", {31'b0, resp_valid}, 32'd0);
        chk("rst_res", resp_result, 32'd0);
        chk("rst_rdy", {31'b0, req_ready}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_ctrl", {29'b0, alu_ctrl}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;

        accept(2'b00, 32'd7, 32'd6, 1'b0);
        wait_resp("mul_7x6", 32'd42, 33, 1'b0);
        accept(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_resp("mul_max", 32'h0000_0001, 33, 1'b0);
        accept(2'b00, 32'h8000_0000, 32'd2, 1'b0);
        wait_resp("mul_ovf", 32'h0000_0000, 33, 1'b0);

        accept(2'b01, 32'd100, 32'd7, 1'b0);
        wait_resp("divu_100_7", 32'd14, 65, 1'b0);
        accept(2'b10, 32'd100, 32'd7, 1'b0);
        wait_resp("remu_100_7", 32'd2, 65, 1'b0);
        accept(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        wait_resp("divu_msb", 32'd1, 65, 1'b0);
        accept(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        wait_resp("remu_msb", 32'h7FFF_FFFE, 65, 1'b0);

        accept(2'b01, 32'd5, 32'd0, 1'b0);
        wait_resp("divu_by0", 32'hFFFF_FFFF, 1, 1'b0);
        accept(2'b10, 32'd5, 32'd0, 1'b0);
        wait_resp("remu_by0", 32'd5, 1, 1'b0);
        accept(2'b11, 32'd9, 32'd4, 1'b0);
        wait_resp("rsvd_op", 32'd0, 1, 1'b0);

        begin : mid_div_reset
            bit seen = 1'b0;
            accept(2'b01, 32'd100, 32'd7, 1'b0);
            for (int i = 1; i < 20; i++) begin
                if (resp_valid === 1'b1) seen = 1'b1;
                @(posedge clk); #1;
            end
            rst = 1'b1;
            #1;
            chk("midrst_rdy_in_rst", {31'b0, req_ready}, 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            #1;
            chk("midrst_rdy_after", {31'b0, req_ready}, 32'd1);
            for (int i = 0; i < 80; i++) begin
                if (resp_valid === 1'b1) seen = 1'b1;
                @(posedge clk); #1;
            end
            chk("midrst_no_resp", {31'b0, seen}, 32'd0);
            chk("midrst_res_cleared", resp_result, 32'd0);
        end
        accept(2'b00, 32'd3, 32'd3, 1'b0);
        wait_resp("mul_3x3", 32'd9, 33, 1'b0);

        accept(2'b00, 32'd5, 32'd4, 1'b1);
        wait_resp("mul_held", 32'd20, 33, 1'b1);
        req_op = 2'b00;
        req_a  = 32'd6;
        req_b  = 32'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b_accepted", {31'b0, req_ready}, 32'd0);
        wait_resp("mul_b2b", 32'd42, 33, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that implements unsigned MUL (low word), DIVU and REMU by iterating the existing single-cycle integer ALU.
- It drives the ALU operand and select ports itself and keeps all shift registers internally.
- It sits beside the execute stage. The execute stage hands it one request at a time through a valid/ready handshake and receives a single-cycle result pulse.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  00 MUL, 01 DIVU, 10 REMU, 11 reserved.
- req_a  in  WIDTH  multiplicand / dividend.
- req_b  in  WIDTH  multiplier / divisor.
- resp_valid  out  1  one-cycle result strobe.
- resp_result  out  WIDTH  result, valid when resp_valid=1.
- alu_a  out  WIDTH  ALU operand a.
- alu_b  out  WIDTH  ALU operand b.
- alu_ctrl  out  3  ALU select: 000 add, 001 sub, 111 set-less-than unsigned.
- alu_out  in  WIDTH  ALU result, combinational from alu_a/alu_b/alu_ctrl.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- States: IDLE, MUL, DIV_CMP, DIV_SUB, DONE.
- Reset:
  - state=IDLE; resp_valid=0; resp_result=0; all internal registers 0.
  - A reset asserted mid-operation discards the in-flight request and produces no resp_valid.
- req_ready = (state==IDLE) & ~rst. No pipelining and no queueing.
- Acceptance: req_valid & req_ready at a rising edge latches op, a and b.
  - req_valid in any other state is ignored; the requester must hold it.
- IDLE transitions on accept:
  - op=00 -> MUL, with acc=0, mcand=a, mplier=b, cnt=0.
  - op=01/10 with b!=0 -> DIV_CMP, with rem=0, dvd=a, dvs=b, quo=0, cnt=0.
  - op=01/10 with b==0 -> DONE, result = 0xFF..F for DIVU, a for REMU.
  - op=11 -> DONE, result=0.
- MUL, WIDTH cycles:
  - alu_ctrl=000, alu_a=acc, alu_b = mplier[0] ? mcand : 0.
  - Each edge: acc<=alu_out; mcand<=mcand<<1; mplier<=mplier>>1; cnt++.
  - After cnt reaches WIDTH-1 -> DONE with result=acc (low WIDTH bits, mod 2^WIDTH).
- DIV_CMP, per iteration:
  - rs = {rem[WIDTH-2:0], dvd[WIDTH-1]}; alu_ctrl=111, alu_a=rs, alu_b=dvs.
  - Register rs into rem, dvd<<=1.
  - Register ge = rem[WIDTH-1] (msb before shift) | ~alu_out[0]. The msb term covers the case where the shifted remainder exceeds WIDTH bits.
  - Then go to DIV_SUB.
- DIV_SUB:
  - alu_ctrl=001, alu_a=rem, alu_b=dvs.
  - If ge: rem<=alu_out (wraps mod 2^WIDTH, which gives the correct value), quo<={quo,1}. Else quo<={quo,0}.
  - cnt++. If cnt was WIDTH-1 -> DONE, else -> DIV_CMP.
  - Result is quo for DIVU, rem for REMU.
- DONE, exactly one cycle:
  - resp_valid=1, resp_result=result, req_ready=0. Then -> IDLE.
  - resp_result holds its value until the next DONE; it resets to 0.
- ALU ports in IDLE and DONE: alu_a=0, alu_b=0, alu_ctrl=000.
- Latency, in cycles from the accept edge to the cycle with resp_valid high:
  - MUL: WIDTH+1.
  - DIVU/REMU: 2*WIDTH+1.
  - Divide-by-zero and reserved op: 1.
- Back-to-back throughput: the next accept is possible in the cycle after DONE.
- No backpressure on the response: the consumer must sample on resp_valid.

Test Plan:
- WIDTH=32, MUL a=7 b=6 accepted at edge 0 -> resp_valid high only in cycle 33, resp_result=42; req_ready=0 in cycles 1..33, then 1.
- MUL a=0xFFFFFFFF b=0xFFFFFFFF -> resp_result=0x00000001. MUL a=0x80000000 b=2 -> 0x00000000.
- DIVU 100/7 -> 14 at cycle 65. REMU 100/7 -> 2. DIVU 0xFFFFFFFF/0x80000001 -> 1, and REMU of the same -> 0x7FFFFFFE (msb-overflow path).
- DIVU 5/0 -> 0xFFFFFFFF at cycle 1; REMU 5/0 -> 5 at cycle 1; reserved op=11 -> 0 at cycle 1.
- Reset mid-DIV: rst=1 for one cycle at cycle 20 -> no resp_valid ever for that request; req_ready=1 the cycle after rst drops; a new MUL 3*3 then returns 9.
- req_valid held high continuously with changing req_a during MUL -> changes ignored, result from the latched operands; the second request is accepted in the cycle after DONE.
